// File: rtl/seq_division_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_division_if                                        |
// | Description : Request/result bundle of the sequential divider:       |
// |               start/operands in, {rem,quo} result and status out.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface seq_division_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     RA;        // divisor
  logic [WIDTH-1:0]     RB;        // dividend
  logic [2*WIDTH-1:0]   RZ;        // {remainder, quotient}
  logic                 busy;
  logic                 done;
  logic                 div_zero;

  // Requester side: issues operations and observes the result.
  modport master (
    output start,
    output is_signed,
    output RA,
    output RB,
    input  RZ,
    input  busy,
    input  done,
    input  div_zero
  );

  // Divider side.
  modport slave (
    input  start,
    input  is_signed,
    input  RA,
    input  RB,
    output RZ,
    output busy,
    output done,
    output div_zero
  );

endinterface
`default_nettype wire

// File: rtl/seq_division.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_division                                           |
// | Description : Multi-cycle restoring divider, one quotient bit per    |
// |               clock, signed/unsigned per operation, divide-by-zero   |
// |               detection, result packed as {remainder, quotient}.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_division #(
  parameter int WIDTH = 32
) (
  input  wire              clock,
  input  wire              clear,
  seq_division_if.slave    bus
);

  // --------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_last = WIDTH'(WIDTH - 1);

  // --------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_next;

  logic [WIDTH-1:0]   r_cnt;       // step counter, W-1 on the last step
  logic [WIDTH-1:0]   r_rem;       // upper half of the partial register
  logic [WIDTH-1:0]   r_quo;       // lower half: dividend shifting out, quotient in
  logic [WIDTH-1:0]   r_dvs;       // divisor magnitude
  logic               r_q_neg;     // quotient must be negated at the end
  logic               r_r_neg;     // remainder must be negated at the end
  logic               r_dz;        // operation is a divide-by-zero

  logic [2*WIDTH-1:0] r_rz;
  logic               r_done;
  logic               r_div_zero;

  // --------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------
  logic               w_busy;
  logic               w_accept;
  logic               w_step;
  logic               w_fix;

  logic               w_ra_zero;
  logic [WIDTH-1:0]   w_ra_mag;
  logic [WIDTH-1:0]   w_rb_mag;

  logic               w_fits;      // trial subtraction is non-negative
  logic [WIDTH-1:0]   w_sub;       // low W bits of the trial difference
  logic [WIDTH-1:0]   w_shift_rem; // remainder after shift, before subtract

  logic [WIDTH-1:0]   w_quo_out;
  logic [WIDTH-1:0]   w_rem_out;

  // Operand magnitudes: in signed mode a negative value is negated, and the
  // most negative value keeps its bit pattern which reads as 2^(W-1) unsigned.
  always_comb begin
    w_ra_zero = (bus.RA == c_zero);
    w_ra_mag  = bus.RA;
    w_rb_mag  = bus.RB;
    if (bus.is_signed && bus.RA[WIDTH-1]) begin
      w_ra_mag = ~bus.RA + c_one;
    end
    if (bus.is_signed && bus.RB[WIDTH-1]) begin
      w_rb_mag = ~bus.RB + c_one;
    end
  end

  // One restoring step: the shifted upper W+1 bits are {rem, quo msb}.
  // Because rem < divisor, the true difference is below 2^W whenever it is
  // non-negative, so the low W bits of a modular subtraction are exact.
  always_comb begin
    w_shift_rem = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    w_fits      = ({r_rem, r_quo[WIDTH-1]} >= {1'b0, r_dvs});
    w_sub       = w_shift_rem - r_dvs;
  end

  // Final sign correction; a divide-by-zero never sets the negate flags.
  always_comb begin
    w_quo_out = r_quo;
    w_rem_out = r_rem;
    if (r_q_neg) begin
      w_quo_out = ~r_quo + c_one;
    end
    if (r_r_neg) begin
      w_rem_out = ~r_rem + c_one;
    end
  end

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = w_ra_zero ? S_FIX : S_ITER;
        end
      end
      S_ITER: begin
        if (r_cnt == c_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State-decoded controls; busy drops in FIX's successor cycle so a new
  // start can be taken in the same cycle that done is high.
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && bus.start;
    w_step   = (r_state == S_ITER);
    w_fix    = (r_state == S_FIX);
  end

  // --------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------

  // Operand capture, iterative restoring steps and the step counter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_ra_zero) begin
        // Divide-by-zero result is prepared directly: all-ones quotient
        // and the untouched dividend as remainder, no sign correction.
        r_rem   <= bus.RB;
        r_quo   <= '1;
        r_dvs   <= '0;
        r_q_neg <= 1'b0;
        r_r_neg <= 1'b0;
        r_dz    <= 1'b1;
      end else begin
        r_rem   <= '0;
        r_quo   <= w_rb_mag;
        r_dvs   <= w_ra_mag;
        r_q_neg <= bus.is_signed && (bus.RA[WIDTH-1] ^ bus.RB[WIDTH-1]);
        r_r_neg <= bus.is_signed && bus.RB[WIDTH-1];
        r_dz    <= 1'b0;
      end
    end else if (w_step) begin
      r_cnt <= r_cnt + c_one;
      if (w_fits) begin
        r_rem <= w_sub;
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift_rem;
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result write-back: RZ and div_zero change only together with done.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_rz       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        r_rz       <= {w_rem_out, w_quo_out};
        r_div_zero <= r_dz;
      end
    end
  end

  assign bus.RZ       = r_rz;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_division.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seq_division                                        |
// | Description : Directed self-checking bench for seq_division, W=32    |
// |               and W=8 instances, hand-computed expected results.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seq_division;

  logic clock = 1'b0;
  logic clear = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  seq_division_if #(.WIDTH(32)) bus32 ();
  seq_division_if #(.WIDTH(8))  bus8  ();

  seq_division #(.WIDTH(32)) dut32 (
    .clock (clock),
    .clear (clear),
    .bus   (bus32.slave)
  );

  seq_division #(.WIDTH(8)) dut8 (
    .clock (clock),
    .clear (clear),
    .bus   (bus8.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done on the 32-bit instance; lat = edges counted.
  task automatic wait_done32(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (bus32.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_done8(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      #1;
      if (bus8.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Issues one request (called 1 ns after a rising edge), scrambles the
  // operand inputs after capture, and waits for the result.
  task automatic run32(input logic s, input logic [31:0] rb, input logic [31:0] ra,
                       output int lat);
    bus32.is_signed = s;
    bus32.RB        = rb;
    bus32.RA        = ra;
    bus32.start     = 1'b1;
    @(posedge clock);
    #1;
    bus32.start     = 1'b0;
    bus32.is_signed = ~s;
    bus32.RB        = 32'h1234_5678;
    bus32.RA        = 32'hDEAD_BEEF;
    wait_done32(lat);
  endtask

  task automatic run8(input logic s, input logic [7:0] rb, input logic [7:0] ra,
                      output int lat);
    bus8.is_signed = s;
    bus8.RB        = rb;
    bus8.RA        = ra;
    bus8.start     = 1'b1;
    @(posedge clock);
    #1;
    bus8.start     = 1'b0;
    bus8.is_signed = ~s;
    bus8.RB        = 8'h5A;
    bus8.RA        = 8'hC3;
    wait_done8(lat);
  endtask

  initial begin
    int lat;
    int done_cnt;

    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.RA = '0; bus32.RB = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.RA  = '0; bus8.RB  = '0;

    // Reset state
    #2;
    chk("rst_rz",    64'(bus32.RZ),       64'h0);
    chk("rst_busy",  64'(bus32.busy),     64'h0);
    chk("rst_done",  64'(bus32.done),     64'h0);
    chk("rst_dz",    64'(bus32.div_zero), 64'h0);
    chk("rst_rz8",   64'(bus8.RZ),        64'h0);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;

    // Unsigned 100 / 7
    run32(1'b0, 32'd100, 32'd7, lat);
    chk("u100_7_lat",  64'(lat),            64'd33);
    chk("u100_7_rz",   64'(bus32.RZ),       64'h00000002_0000000E);
    chk("u100_7_dz",   64'(bus32.div_zero), 64'h0);
    chk("u100_7_busy", 64'(bus32.busy),     64'h0);
    @(posedge clock); #1;
    chk("done_pulse",  64'(bus32.done),     64'h0);
    chk("rz_hold",     64'(bus32.RZ),       64'h00000002_0000000E);

    // Signed -100 / 7 and 100 / -7
    run32(1'b1, 32'hFFFF_FF9C, 32'd7, lat);
    chk("sm100_7_lat", 64'(lat),            64'd33);
    chk("sm100_7_rz",  64'(bus32.RZ),       64'hFFFFFFFE_FFFFFFF2);
    run32(1'b1, 32'd100, 32'hFFFF_FFF9, lat);
    chk("s100_m7_rz",  64'(bus32.RZ),       64'h00000002_FFFFFFF2);

    // Divide-by-zero, both modes, plus a negative dividend kept unmodified
    run32(1'b0, 32'd5, 32'd0, lat);
    chk("dz_u_lat",    64'(lat),            64'd1);
    chk("dz_u_rz",     64'(bus32.RZ),       64'h00000005_FFFFFFFF);
    chk("dz_u_flag",   64'(bus32.div_zero), 64'h1);
    run32(1'b1, 32'd5, 32'd0, lat);
    chk("dz_s_lat",    64'(lat),            64'd1);
    chk("dz_s_rz",     64'(bus32.RZ),       64'h00000005_FFFFFFFF);
    chk("dz_s_flag",   64'(bus32.div_zero), 64'h1);
    run32(1'b1, 32'hFFFF_FFFB, 32'd0, lat);
    chk("dz_neg_rz",   64'(bus32.RZ),       64'hFFFFFFFB_FFFFFFFF);
    repeat (3) @(posedge clock);
    #1;
    chk("dz_hold",     64'(bus32.div_zero), 64'h1);
    run32(1'b0, 32'd100, 32'd7, lat);
    chk("dz_clr_flag", 64'(bus32.div_zero), 64'h0);
    chk("dz_clr_rz",   64'(bus32.RZ),       64'h00000002_0000000E);

    // Signed overflow and the same operands unsigned
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("ovf_s_rz",    64'(bus32.RZ),       64'h00000000_80000000);
    run32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("ovf_u_rz",    64'(bus32.RZ),       64'h80000000_00000000);

    // Handshake: start during busy is ignored
    bus32.is_signed = 1'b0; bus32.RB = 32'd100; bus32.RA = 32'd7; bus32.start = 1'b1;
    @(posedge clock); #1;
    bus32.start = 1'b0;
    chk("hs_busy",     64'(bus32.busy),     64'h1);
    repeat (9) @(posedge clock);
    #1;
    bus32.RB = 32'd9; bus32.RA = 32'd2; bus32.start = 1'b1;
    @(posedge clock); #1;
    bus32.start = 1'b0;
    wait_done32(lat);
    chk("hs_ign_lat",  64'(lat),            64'd23);
    chk("hs_ign_rz",   64'(bus32.RZ),       64'h00000002_0000000E);

    // Start in the done cycle is accepted
    bus32.RB = 32'd9; bus32.RA = 32'd2; bus32.start = 1'b1;
    @(posedge clock); #1;
    bus32.start = 1'b0;
    chk("b2b_busy",    64'(bus32.busy),     64'h1);
    wait_done32(lat);
    chk("b2b_lat",     64'(lat),            64'd33);
    chk("b2b_rz",      64'(bus32.RZ),       64'h00000001_00000004);

    // Asynchronous clear in the middle of an operation
    bus32.RB = 32'd100; bus32.RA = 32'd7; bus32.start = 1'b1;
    @(posedge clock); #1;
    bus32.start = 1'b0;
    repeat (19) @(posedge clock);
    #3;
    clear = 1'b0;
    #1;
    chk("clr_rz",      64'(bus32.RZ),       64'h0);
    chk("clr_busy",    64'(bus32.busy),     64'h0);
    chk("clr_done",    64'(bus32.done),     64'h0);
    chk("clr_dz",      64'(bus32.div_zero), 64'h0);
    @(posedge clock); #1;
    clear = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clock);
      #1;
      if (bus32.done === 1'b1) done_cnt++;
    end
    chk("clr_no_done", 64'(done_cnt),       64'd0);

    // W=8 instance
    run8(1'b0, 8'd200, 8'd3, lat);
    chk("w8_u_lat",    64'(lat),            64'd9);
    chk("w8_u_rz",     64'(bus8.RZ),        64'h0242);
    chk("w8_u_dz",     64'(bus8.div_zero),  64'h0);
    run8(1'b1, 8'h80, 8'hFF, lat);
    chk("w8_ovf_rz",   64'(bus8.RZ),        64'h0080);
    run8(1'b1, 8'hF9, 8'h00, lat);
    chk("w8_dz_lat",   64'(lat),            64'd1);
    chk("w8_dz_rz",    64'(bus8.RZ),        64'hF9FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
